// File: rtl/cnn_pkg.sv
// Shared types and helpers for the digit-recognition CNN datapath.
// Holds data/address widths, the pooling FSM state encoding and a signed max.
package cnn_pkg;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 14;
    localparam int ADDR_SPACE = 16384;

    typedef logic signed [DATA_W-1:0] data_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD0  = 3'd1,
        ST_RD1  = 3'd2,
        ST_RD2  = 3'd3,
        ST_RD3  = 3'd4,
        ST_WR   = 3'd5,
        ST_DONE = 3'd6
    } pool_state_e;

    // Both operands are data_t, so the compare is signed (0x80000000 is the minimum).
    function automatic data_t smax(input data_t a, input data_t b);
        smax = (a > b) ? a : b;
    endfunction

    function automatic data_t relu(input data_t a);
        relu = (a < $signed(32'sd0)) ? $signed(32'sd0) : a;
    endfunction

endpackage

// File: rtl/pool_addr_gen.sv
// Window address generator for the 2x2 stride-2 pooling stage: channel / pooled
// row / pooled column counters plus the tap offset inside the current window.
module pool_addr_gen
    import cnn_pkg::*;
#(
    parameter int IN_DIM   = 28,
    parameter int CHANNELS = 6,
    parameter int IN_BASE  = 0,
    parameter int OUT_BASE = 0
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              clear,
    input  logic              step,
    input  logic              advance,
    output logic [ADDR_W-1:0] rdaddr,
    output logic [ADDR_W-1:0] wraddr,
    output logic              last_window
);

    localparam int OUT_DIM = IN_DIM / 2;
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PW      = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(CHANNELS - 1);
    localparam logic [PW-1:0] P_LAST = PW'(OUT_DIM - 1);

    logic [CW-1:0]     c_r, c_s;
    logic [PW-1:0]     pr_r, pr_s, pc_r, pc_s;
    logic [1:0]        tap_r, tap_s;
    logic [PW:0]       row_s, col_s;
    logic [ADDR_W-1:0] rd_next_s, wr_cur_s;
    logic [ADDR_W-1:0] rdaddr_r, wraddr_r;

    // Next counter values: tap walks TL,TR,BL,BR; window advance wraps pc -> pr -> c.
    always_comb begin
        c_s   = c_r;
        pr_s  = pr_r;
        pc_s  = pc_r;
        tap_s = tap_r;
        if (clear) begin
            c_s   = CW'(0);
            pr_s  = PW'(0);
            pc_s  = PW'(0);
            tap_s = 2'd0;
        end else if (advance) begin
            tap_s = 2'd0;
            if (pc_r != P_LAST) begin
                pc_s = pc_r + PW'(1);
            end else begin
                pc_s = PW'(0);
                if (pr_r != P_LAST) begin
                    pr_s = pr_r + PW'(1);
                end else begin
                    pr_s = PW'(0);
                    if (c_r != C_LAST) begin
                        c_s = c_r + CW'(1);
                    end else begin
                        c_s = CW'(0);
                    end
                end
            end
        end else if (step) begin
            tap_s = tap_r + 2'd1;
        end else begin
            tap_s = tap_r;
        end
    end

    // Read address follows the next counters so it is registered alongside them.
    always_comb begin
        row_s     = {pr_s, tap_s[1]};
        col_s     = {pc_s, tap_s[0]};
        rd_next_s = ADDR_W'(IN_BASE + int'(c_s) * (IN_DIM * IN_DIM)
                            + int'(row_s) * IN_DIM + int'(col_s));
        wr_cur_s  = ADDR_W'(OUT_BASE + int'(c_r) * (OUT_DIM * OUT_DIM)
                            + int'(pr_r) * OUT_DIM + int'(pc_r));
    end

    // Counter and address registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            c_r      <= CW'(0);
            pr_r     <= PW'(0);
            pc_r     <= PW'(0);
            tap_r    <= 2'd0;
            rdaddr_r <= {ADDR_W{1'b0}};
            wraddr_r <= {ADDR_W{1'b0}};
        end else begin
            c_r   <= c_s;
            pr_r  <= pr_s;
            pc_r  <= pc_s;
            tap_r <= tap_s;
            if (clear || step || advance) begin
                rdaddr_r <= rd_next_s;
            end else begin
                rdaddr_r <= rdaddr_r;
            end
            // Captured as the window retires, before the counters move on.
            if (advance) begin
                wraddr_r <= wr_cur_s;
            end else begin
                wraddr_r <= wraddr_r;
            end
        end
    end

    assign rdaddr      = rdaddr_r;
    assign wraddr      = wraddr_r;
    assign last_window = (c_r == C_LAST) && (pr_r == P_LAST) && (pc_r == P_LAST);

endmodule

// File: rtl/maxpool_relu_stage.sv
// 2x2 stride-2 max-pool stage between two intermediate RAMs, with optional ReLU
// on the pooled value when MAXPOOL_RELU_EN is defined (raw signed max otherwise).
module maxpool_relu_stage
    import cnn_pkg::*;
#(
    parameter int IN_DIM   = 28,
    parameter int CHANNELS = 6,
    parameter int IN_BASE  = 0,
    parameter int OUT_BASE = 0
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_W-1:0]        rdaddr,
    input  logic signed [DATA_W-1:0] rddata,
    output logic                     wren,
    output logic [ADDR_W-1:0]        wraddr,
    output logic signed [DATA_W-1:0] wrdata
);

    localparam int OUT_DIM = IN_DIM / 2;

    if ((IN_DIM % 2) != 0) begin : g_odd_dim
        $error("maxpool_relu_stage: IN_DIM must be even");
    end
    if (IN_BASE + CHANNELS * IN_DIM * IN_DIM > ADDR_SPACE) begin : g_in_range
        $error("maxpool_relu_stage: input tensor exceeds address space");
    end
    if (OUT_BASE + CHANNELS * OUT_DIM * OUT_DIM > ADDR_SPACE) begin : g_out_range
        $error("maxpool_relu_stage: output tensor exceeds address space");
    end

    pool_state_e state_r, next_s;
    logic        clear_s, step_s, advance_s, last_window_s;
    data_t       max_r, final_s, pool_out_s;
    logic        busy_r, done_r, wren_r;
    data_t       wrdata_r;

    pool_addr_gen #(
        .IN_DIM   (IN_DIM),
        .CHANNELS (CHANNELS),
        .IN_BASE  (IN_BASE),
        .OUT_BASE (OUT_BASE)
    ) u_addr (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .clear       (clear_s),
        .step        (step_s),
        .advance     (advance_s),
        .rdaddr      (rdaddr),
        .wraddr      (wraddr),
        .last_window (last_window_s)
    );

    // Next-state and counter control.
    always_comb begin
        next_s    = state_r;
        clear_s   = 1'b0;
        step_s    = 1'b0;
        advance_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_s  = ST_RD0;
                    clear_s = 1'b1;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_RD0: begin
                next_s = ST_RD1;
                step_s = 1'b1;
            end
            ST_RD1: begin
                next_s = ST_RD2;
                step_s = 1'b1;
            end
            ST_RD2: begin
                next_s = ST_RD3;
                step_s = 1'b1;
            end
            ST_RD3: next_s = ST_WR;
            ST_WR: begin
                advance_s = 1'b1;
                if (last_window_s) begin
                    next_s = ST_DONE;
                end else begin
                    next_s = ST_RD0;
                end
            end
            ST_DONE: next_s = ST_IDLE;
            default: next_s = ST_IDLE;
        endcase
    end

    // Final max folds in the bottom-right tap, which arrives during WR.
    always_comb begin
        final_s = smax(max_r, rddata);
`ifdef MAXPOOL_RELU_EN
        pool_out_s = relu(final_s);
`else
        pool_out_s = final_s;
`endif
    end

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Running window max; rddata during RDn belongs to the read issued in RD(n-1).
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            max_r <= $signed(32'sd0);
        end else begin
            case (state_r)
                ST_RD1:  max_r <= rddata;
                ST_RD2:  max_r <= smax(max_r, rddata);
                ST_RD3:  max_r <= smax(max_r, rddata);
                default: max_r <= max_r;
            endcase
        end
    end

    // Registered status and write-port outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            wren_r   <= 1'b0;
            wrdata_r <= $signed(32'sd0);
        end else begin
            busy_r <= (next_s != ST_IDLE);
            done_r <= (state_r == ST_DONE);
            wren_r <= (state_r == ST_WR);
            if (state_r == ST_WR) begin
                wrdata_r <= pool_out_s;
            end else begin
                wrdata_r <= wrdata_r;
            end
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign wren   = wren_r;
    assign wrdata = wrdata_r;

endmodule

// File: tb/tb_maxpool_relu_stage.sv
// Directed bench: a 4x4x1 instance for hand-computed windows and reset behaviour,
// and a 28x28x6 instance checked against a bench-side pooling model.
module tb_maxpool_relu_stage;

    localparam int A_IN  = 100;
    localparam int A_OUT = 200;
    localparam int B_OUT = 300;
    localparam int B_N   = 1176;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start_a, start_b;
    logic busy_a, done_a, wren_a, busy_b, done_b, wren_b;
    logic [13:0] rdaddr_a, wraddr_a, rdaddr_b, wraddr_b;
    logic signed [31:0] rddata_a, wrdata_a, rddata_b, wrdata_b;

    maxpool_relu_stage #(.IN_DIM(4), .CHANNELS(1), .IN_BASE(A_IN), .OUT_BASE(A_OUT)) dut_a (
        .Clk(clk), .Reset_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
        .rdaddr(rdaddr_a), .rddata(rddata_a), .wren(wren_a), .wraddr(wraddr_a), .wrdata(wrdata_a)
    );

    maxpool_relu_stage #(.IN_DIM(28), .CHANNELS(6), .IN_BASE(0), .OUT_BASE(B_OUT)) dut_b (
        .Clk(clk), .Reset_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
        .rdaddr(rdaddr_b), .rddata(rddata_b), .wren(wren_b), .wraddr(wraddr_b), .wrdata(wrdata_b)
    );

    // RAM models: address captured on negedge, data presented on the following posedge.
    logic [31:0] src_a [0:16383];
    logic [31:0] src_b [0:16383];
    logic [13:0] ra_a_q, ra_b_q;
    logic [31:0] wa_a [$], wd_a [$], wa_b [$], wd_b [$];
    int ndone_a = 0;

    always @(negedge clk) begin
        ra_a_q <= rdaddr_a;
        ra_b_q <= rdaddr_b;
    end
    always @(posedge clk) begin
        rddata_a <= src_a[ra_a_q];
        rddata_b <= src_b[ra_b_q];
    end
    always @(negedge clk) begin
        if (wren_a === 1'b1) begin
            wa_a.push_back(32'(wraddr_a));
            wd_a.push_back(wrdata_a);
        end
        if (wren_b === 1'b1) begin
            wa_b.push_back(32'(wraddr_b));
            wd_b.push_back(wrdata_b);
        end
        if (done_a === 1'b1) ndone_a++;
    end

    int n_pass = 0, n_fail = 0, n_total = 0;
    logic [31:0] win_vals [16];
    logic [31:0] exp_a [4];
    logic [31:0] exp_b [B_N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic signed [31:0] tmax(input logic signed [31:0] a, input logic signed [31:0] b);
        return (a >= b) ? a : b;
    endfunction

    task automatic pulse_start_a();
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
    endtask

    task automatic wait_done_a(output int de, output logic busy_before);
        de = -1;
        busy_before = 1'b0;
        for (int e = 1; e <= 80 && de < 0; e++) begin
            @(posedge clk); #1;
            if (done_a === 1'b1) de = e;
            else busy_before = busy_a;
        end
    endtask

    task automatic check_run_a(input int q0, input string tag);
        check({tag, "_wren_count"}, 32'(wa_a.size() - q0), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (q0 + k < wa_a.size()) begin
                check($sformatf("%s_addr%0d", tag, k), wa_a[q0 + k], 32'(A_OUT + k));
                check($sformatf("%s_data%0d", tag, k), wd_a[q0 + k], exp_a[k]);
            end
        end
    endtask

    task automatic run_b(input string tag, input bit repulse);
        int q0, de, errs;
        q0 = wa_b.size();
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        de = -1;
        for (int e = 1; e <= 6500 && de < 0; e++) begin
            @(posedge clk); #1;
            if (done_b === 1'b1) de = e;
            start_b = (repulse && (e == 2 || e == 99)) ? 1'b1 : 1'b0;
        end
        start_b = 1'b0;
        check({tag, "_done_cycle"}, 32'(de), 32'd5881);
        check({tag, "_write_count"}, 32'(wa_b.size() - q0), 32'(B_N));
        errs = 0;
        for (int k = 0; k < B_N; k++) begin
            if (q0 + k < wa_b.size()) begin
                if (wa_b[q0 + k] !== 32'(B_OUT + k) || wd_b[q0 + k] !== exp_b[k]) errs++;
            end
        end
        check({tag, "_addr_data_errs"}, 32'(errs), 32'd0);
    endtask

    initial begin
        int q0, nd0, de;
        logic bb;

        rst_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        win_vals = '{32'hFFFFFFF8, 32'hFFFFFFFD, 32'h80000000, 32'h7FFFFFFF,
                     32'hFFFFFFFB, 32'hFFFFFFF7, 32'hFFFFFFFF, 32'h00000000,
                     32'h00000001, 32'hFFFFFFFF, 32'hFFFFFC18, 32'hFFFFFC19,
                     32'h00000002, 32'hFFFFFFFE, 32'hFFFFFC17, 32'hFFFFFC1A};
        #12;
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_wren", 32'(wren_a), 32'd0);
        check("rst_rdaddr", 32'(rdaddr_a), 32'd0);
        check("rst_wraddr", 32'(wraddr_a), 32'd0);
        check("rst_wrdata", wrdata_a, 32'd0);
        rst_n = 1'b1;

        // Ramp 0..15: windows pool to 5, 7, 13, 15.
        for (int i = 0; i < 16; i++) src_a[A_IN + i] = 32'(i);
        exp_a = '{32'd5, 32'd7, 32'd13, 32'd15};
        q0 = wa_a.size();
        nd0 = ndone_a;
        pulse_start_a();
        check("a1_busy_rise", 32'(busy_a), 32'd1);
        wait_done_a(de, bb);
        check("a1_done_cycle", 32'(de), 32'd21);
        check("a1_busy_before_done", 32'(bb), 32'd1);
        check("a1_busy_fall", 32'(busy_a), 32'd0);
        repeat (3) @(posedge clk);
        #1 check("a1_done_pulses", 32'(ndone_a - nd0), 32'd1);
        check_run_a(q0, "a1");

        // Negative / extreme windows, reset asynchronously mid-run at cycle 12.
        for (int i = 0; i < 16; i++) src_a[A_IN + i] = win_vals[i];
`ifdef MAXPOOL_RELU_EN
        exp_a = '{32'h00000000, 32'h7FFFFFFF, 32'h00000002, 32'h00000000};
`else
        exp_a = '{32'hFFFFFFFD, 32'h7FFFFFFF, 32'h00000002, 32'hFFFFFC1A};
`endif
        q0 = wa_a.size();
        nd0 = ndone_a;
        pulse_start_a();
        repeat (12) @(posedge clk);
        #3 check("rr_busy_pre", 32'(busy_a), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rr_busy_async", 32'(busy_a), 32'd0);
        check("rr_wren_async", 32'(wren_a), 32'd0);
        check("rr_wraddr_async", 32'(wraddr_a), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("rr_no_done", 32'(ndone_a - nd0), 32'd0);
        check("rr_partial_writes", 32'(wa_a.size() - q0), 32'd2);
        check("rr_idle_busy", 32'(busy_a), 32'd0);

        // Fresh start after reset.
        q0 = wa_a.size();
        pulse_start_a();
        wait_done_a(de, bb);
        check("a2_done_cycle", 32'(de), 32'd21);
        check_run_a(q0, "a2");

        // Full-size map with random data and a bench-side reference model.
        for (int i = 0; i < 6 * 784; i++) src_b[i] = $urandom();
        src_b[0] = 32'h80000000;
        src_b[1] = 32'h7FFFFFFF;
        src_b[28] = 32'hFFFFFFFF;
        src_b[29] = 32'h00000000;
        for (int c = 0; c < 6; c++) begin
            for (int pr = 0; pr < 14; pr++) begin
                for (int pc = 0; pc < 14; pc++) begin
                    int b;
                    logic signed [31:0] m;
                    b = c * 784 + 2 * pr * 28 + 2 * pc;
                    m = tmax(tmax(src_b[b], src_b[b + 1]), tmax(src_b[b + 28], src_b[b + 29]));
`ifdef MAXPOOL_RELU_EN
                    if (m < 0) m = 0;
`endif
                    exp_b[c * 196 + pr * 14 + pc] = m;
                end
            end
        end
        check("b_extreme_window_model", exp_b[0], 32'h7FFFFFFF);
        run_b("b1", 1'b1);
        run_b("b2", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
